read_control_gray: RTL and testbench
====================================

Name: read_control_gray

Overview:
- Parametrised next-generation FIFO read-side controller in the rd_clk domain.
- Replaces the fixed-width enable-on-not-empty counter with:
  - a handshaked read (rd_en);
  - binary and Gray read pointers;
  - locally generated empty and almost-empty flags, computed from the synchronised write-pointer Gray code;
  - a fill-level output, read-valid strobe and sticky underflow flag.
- Sits between the dual-port RAM read port, the write-to-read pointer synchroniser and the FIFO top.

Parameters:
- A_LENGTH, 3, address width; FIFO depth = 2^A_LENGTH; pointers are A_LENGTH+1 bits.
- AE_THRESH, 1, almost-empty threshold; f_almost_empty asserts when level <= AE_THRESH. Legal range 0..2^A_LENGTH.

Ports:
- rd_clk  input  1  read-domain clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- rd_en  input  1  read request from consumer.
- clr_underflow  input  1  synchronous clear of the underflow flag.
- wr_ptr_gray_sync  input  A_LENGTH+1  write pointer Gray code, already synchronised into rd_clk.
- b_rd_ptr  output  A_LENGTH  RAM read address (rd_ptr_bin[A_LENGTH-1:0]).
- rd_ptr_bin  output  A_LENGTH+1  binary read pointer including wrap MSB.
- rd_ptr_gray  output  A_LENGTH+1  registered Gray read pointer, sent to the write-domain synchroniser.
- f_empty  output  1  FIFO empty.
- f_almost_empty  output  1  level <= AE_THRESH.
- rd_level  output  A_LENGTH+1  words available, range 0..2^A_LENGTH.
- rd_valid  output  1  RAM read data valid this cycle.
- underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Reset, synchronous active-high, sampled on rd_clk:
  - rd_ptr_bin = 0, rd_ptr_gray = 0, b_rd_ptr = 0;
  - f_empty = 1, f_almost_empty = 1, rd_level = 0, rd_valid = 0, underflow = 0.
  - Reset has priority over every other input in the same cycle.
  - Reset asserted mid-operation discards state in the next cycle; there is no drain.
- Accepted read:
  - rd_fire = rd_en & ~f_empty, evaluated on registered f_empty.
  - rd_en while f_empty is ignored: pointers and level are held.
- Pointer update:
  - rd_ptr_bin_next = rd_ptr_bin + rd_fire, modulo 2^(A_LENGTH+1). Natural wrap; MSB toggles each pass through the address space.
  - rd_ptr_gray registered from rd_ptr_bin_next ^ (rd_ptr_bin_next >> 1). It is updated in the same cycle as rd_ptr_bin; there is no extra Gray latency.
  - Only one Gray bit changes per increment, including the wrap 2^(A_LENGTH+1)-1 -> 0.
- Empty:
  - f_empty registered as (Gray(rd_ptr_bin_next) == wr_ptr_gray_sync).
  - Deasserts one cycle after wr_ptr_gray_sync changes away from the read pointer.
  - Asserts in the same edge as the last accepted read, so no read past the last word is possible.
- Level:
  - wr_bin = Gray-to-binary of wr_ptr_gray_sync (XOR prefix from MSB).
  - rd_level registered = (wr_bin - rd_ptr_bin_next) modulo 2^(A_LENGTH+1).
  - Maximum value 2^A_LENGTH, which means full.
- Almost-empty: f_almost_empty registered = (level_next <= AE_THRESH), where level_next is the value being loaded into rd_level.
- Read valid:
  - rd_valid = rd_fire delayed one cycle, matching the one-cycle synchronous RAM read latency.
  - Back-to-back reads give back-to-back rd_valid.
- Underflow:
  - Set on any cycle with rd_en & f_empty.
  - Cleared by reset or clr_underflow.
  - A set and a clear in the same cycle result in set (set wins).
- Write-pointer motion concurrent with a read: both are reflected in the same registered level and empty update. Example: level stays constant if one write arrives and one read fires.
- Static invariant: f_empty == (rd_level == 0) on every cycle after reset.

Test Plan:
- Reset state, A_LENGTH=3: assert reset 2 cycles with rd_en=1 -> all pointers 0, f_empty=1, f_almost_empty=1, rd_level=0, rd_valid=0, underflow=0.
- Fill then drain: wr_ptr_gray_sync stepped 0->Gray(5)=4'b0111, then rd_en held high.
  - rd_level reaches 5; f_empty drops one cycle after.
  - Exactly 5 rd_valid pulses occur; b_rd_ptr runs 0..4.
  - f_empty=1 on the edge of the 5th accept; rd_level=0.
- Wrap: run 20 write/read pairs with depth 8.
  - rd_ptr_bin passes 15->0 and rd_ptr_gray 4'b1000->4'b0000.
  - Each Gray transition has Hamming distance 1; b_rd_ptr wraps 7->0.
- Almost-empty, AE_THRESH=2: level sequence 4,3,2,1,0 -> f_almost_empty = 0,0,1,1,1, and f_empty=1 only at 0.
- Underflow: rd_en=1 while empty for 1 cycle -> underflow=1 and stays 1 with pointers unchanged.
  - clr_underflow=1 with rd_en=0 -> 0 next cycle.
  - clr_underflow=1 and rd_en=1 while empty -> remains 1.
- Simultaneous write and read at level 3, with wr_ptr advancing by 1 and rd_fire=1 -> rd_level stays 3 and rd_valid=1. Then reset mid-stream -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/read_control_gray_if.sv
// Read-side FIFO controller bundle: consumer handshake, synchronised write
// pointer in, read pointers, flags and level out.
interface read_control_gray_if #(
  parameter int A_LENGTH = 3
);
  logic                rd_en;
  logic                clr_underflow;
  logic [A_LENGTH:0]   wr_ptr_gray_sync;
  logic [A_LENGTH-1:0] b_rd_ptr;
  logic [A_LENGTH:0]   rd_ptr_bin;
  logic [A_LENGTH:0]   rd_ptr_gray;
  logic                f_empty;
  logic                f_almost_empty;
  logic [A_LENGTH:0]   rd_level;
  logic                rd_valid;
  logic                underflow;

  // FIFO top / consumer side
  modport master (
    output rd_en, clr_underflow, wr_ptr_gray_sync,
    input  b_rd_ptr, rd_ptr_bin, rd_ptr_gray, f_empty, f_almost_empty,
           rd_level, rd_valid, underflow
  );

  // read controller side
  modport slave (
    input  rd_en, clr_underflow, wr_ptr_gray_sync,
    output b_rd_ptr, rd_ptr_bin, rd_ptr_gray, f_empty, f_almost_empty,
           rd_level, rd_valid, underflow
  );
endinterface

// File: rtl/read_control_gray.sv
// FIFO read-side controller (rd_clk domain): handshaked reads, binary/Gray
// read pointers, empty/almost-empty flags from the synchronised write Gray
// pointer, fill level, read-valid strobe and sticky underflow.
module read_control_gray #(
  parameter int A_LENGTH  = 3,
  parameter int AE_THRESH = 1
) (
  input  logic                 rd_clk,
  input  logic                 reset,
  read_control_gray_if.slave   rif
);
  localparam int PW = A_LENGTH + 1;
  localparam logic [PW-1:0] LP_AE = PW'(AE_THRESH);

  logic [PW-1:0] r_rd_ptr_bin;
  logic [PW-1:0] r_rd_ptr_gray;
  logic [PW-1:0] r_rd_level;
  logic          r_f_empty;
  logic          r_f_almost_empty;
  logic          r_rd_valid;
  logic          r_underflow;

  logic          w_rd_fire;
  logic [PW-1:0] w_bin_next;
  logic [PW-1:0] w_gray_next;
  logic [PW-1:0] w_wr_bin;
  logic [PW-1:0] w_level_next;

  // Reads are only accepted against the registered empty flag, so the
  // pointer can never step past the last written word.
  assign w_rd_fire    = rif.rd_en & ~r_f_empty;
  assign w_bin_next   = r_rd_ptr_bin + PW'(w_rd_fire);
  assign w_gray_next  = w_bin_next ^ (w_bin_next >> 1);
  assign w_level_next = w_wr_bin - w_bin_next;

  // Gray-to-binary of the write pointer: each bit is the XOR of all Gray
  // bits at and above it.
  always_comb begin
    w_wr_bin = '0;
    for (int i = 0; i < PW; i++)
      w_wr_bin[i] = ^(rif.wr_ptr_gray_sync >> i);
  end

  // Pointer, flag and level registers; flags are computed from the next
  // pointer so empty asserts on the same edge as the last accepted read.
  always_ff @(posedge rd_clk) begin
    if (reset) begin
      r_rd_ptr_bin     <= '0;
      r_rd_ptr_gray    <= '0;
      r_rd_level       <= '0;
      r_f_empty        <= 1'b1;
      r_f_almost_empty <= 1'b1;
      r_rd_valid       <= 1'b0;
    end else begin
      r_rd_ptr_bin     <= w_bin_next;
      r_rd_ptr_gray    <= w_gray_next;
      r_rd_level       <= w_level_next;
      r_f_empty        <= (w_gray_next == rif.wr_ptr_gray_sync);
      r_f_almost_empty <= (w_level_next <= LP_AE);
      r_rd_valid       <= w_rd_fire;
    end
  end

  // Sticky underflow: a read attempt while empty wins over a same-cycle clear.
  always_ff @(posedge rd_clk) begin
    if (reset)
      r_underflow <= 1'b0;
    else if (rif.rd_en & r_f_empty)
      r_underflow <= 1'b1;
    else if (rif.clr_underflow)
      r_underflow <= 1'b0;
  end

  assign rif.b_rd_ptr       = r_rd_ptr_bin[A_LENGTH-1:0];
  assign rif.rd_ptr_bin     = r_rd_ptr_bin;
  assign rif.rd_ptr_gray    = r_rd_ptr_gray;
  assign rif.f_empty        = r_f_empty;
  assign rif.f_almost_empty = r_f_almost_empty;
  assign rif.rd_level       = r_rd_level;
  assign rif.rd_valid       = r_rd_valid;
  assign rif.underflow      = r_underflow;
endmodule

// File: tb/tb_read_control_gray.sv
// Scoreboard bench for read_control_gray: a count-based model predicts the
// post-edge state for every driven cycle; read addresses are queued on accept
// and matched against rd_valid strobes.
module tb_read_control_gray;
  localparam int A  = 3;
  localparam int AE = 2;

  logic rd_clk = 1'b0;
  logic reset  = 1'b1;

  read_control_gray_if #(.A_LENGTH(A)) rif ();

  read_control_gray #(.A_LENGTH(A), .AE_THRESH(AE)) dut (
    .rd_clk (rd_clk),
    .reset  (reset),
    .rif    (rif)
  );

  always #5 rd_clk = ~rd_clk;

  typedef struct {
    logic [4:0] bin;
    logic [4:0] gray;
    logic [4:0] lvl;
    logic       e;
    logic       ae;
    logic       vld;
    logic       uf;
  } exp_t;

  exp_t exp_q[$];
  int   addr_q[$];

  int n_chk = 0;
  int n_err = 0;

  // model state
  int   wr_cnt = 0;
  int   m_rd   = 0;
  logic me = 1'b1, mae = 1'b1, mvld = 1'b0, muf = 1'b0;
  int   mlvl = 0;

  // observation helpers
  logic [4:0] prev_gray = '0;
  logic [4:0] prev_bin  = '0;
  int   vld_cnt = 0;
  logic saw_bin_wrap = 1'b0, saw_gray_wrap = 1'b0, saw_addr_wrap = 1'b0;

  function automatic logic [4:0] to_gray(input int v);
    logic [4:0] b;
    b = v[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model, push the prediction, then
  // pop and compare after the edge.
  task automatic cyc(input logic en, input logic clr, input logic rst);
    exp_t e;
    logic fire;
    rif.rd_en            = en;
    rif.clr_underflow    = clr;
    rif.wr_ptr_gray_sync = to_gray(wr_cnt % 16);
    reset                = rst;
    if (rst) begin
      m_rd = 0; mlvl = 0; me = 1'b1; mae = 1'b1; mvld = 1'b0; muf = 1'b0;
      addr_q.delete();
    end else begin
      fire = en && !me;
      if (en && me) muf = 1'b1;
      else if (clr) muf = 1'b0;
      if (fire) begin
        addr_q.push_back(m_rd % 8);
        m_rd++;
      end
      mlvl = (wr_cnt - m_rd) % 16;
      me   = (mlvl == 0);
      mae  = (mlvl <= AE);
      mvld = fire;
    end
    e.bin = 5'(m_rd % 16); e.gray = to_gray(m_rd % 16); e.lvl = 5'(mlvl);
    e.e = me; e.ae = mae; e.vld = mvld; e.uf = muf;
    e.bin[4] = 1'b0; e.gray[4] = 1'b0; e.lvl[4] = 1'b0;
    exp_q.push_back(e);

    @(posedge rd_clk);
    #1;
    e = exp_q.pop_front();
    chk("rd_ptr_bin",     32'(rif.rd_ptr_bin),     32'(e.bin[3:0]));
    chk("rd_ptr_gray",    32'(rif.rd_ptr_gray),    32'(e.gray[3:0]));
    chk("b_rd_ptr",       32'(rif.b_rd_ptr),       32'(e.bin[2:0]));
    chk("rd_level",       32'(rif.rd_level),       32'(e.lvl[3:0]));
    chk("f_empty",        32'(rif.f_empty),        32'(e.e));
    chk("f_almost_empty", 32'(rif.f_almost_empty), 32'(e.ae));
    chk("rd_valid",       32'(rif.rd_valid),       32'(e.vld));
    chk("underflow",      32'(rif.underflow),      32'(e.uf));
    chk("empty_inv",      32'(rif.f_empty),        32'(rif.rd_level == 4'd0));
    chk("gray_hd",        32'($countones({1'b0, rif.rd_ptr_gray} ^ prev_gray) <= 1), 32'd1);
    if (rif.rd_valid === 1'b1) begin
      vld_cnt++;
      if (addr_q.size() == 0)
        chk("rd_valid_unexpected", 32'd1, 32'd0);
      else
        chk("rd_addr", 32'(3'(rif.b_rd_ptr - 3'd1)), 32'(addr_q.pop_front()));
    end
    if (prev_bin[3:0] == 4'hF && rif.rd_ptr_bin == 4'h0) saw_bin_wrap = 1'b1;
    if (prev_gray[3:0] == 4'b1000 && rif.rd_ptr_gray == 4'b0000) saw_gray_wrap = 1'b1;
    if (prev_bin[2:0] == 3'd7 && rif.b_rd_ptr == 3'd0 && prev_bin[3:0] != rif.rd_ptr_bin)
      saw_addr_wrap = 1'b1;
    prev_gray = {1'b0, rif.rd_ptr_gray};
    prev_bin  = {1'b0, rif.rd_ptr_bin};
  endtask

  initial begin
    rif.rd_en = 1'b0;
    rif.clr_underflow = 1'b0;
    rif.wr_ptr_gray_sync = '0;

    // reset held two cycles with rd_en asserted
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);

    // fill to 5, then drain with rd_en held while data remains
    for (int i = 0; i < 5; i++) begin
      wr_cnt++;
      cyc(1'b0, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b0, 1'b0);
    chk("fill_level", 32'(rif.rd_level), 32'd5);
    vld_cnt = 0;
    for (int i = 0; i < 20 && !me; i++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("drain_vld_cnt", 32'(vld_cnt), 32'd5);
    chk("drain_empty", 32'(rif.f_empty), 32'd1);

    // underflow: set, hold, clear, set-wins-over-clear, clear
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);

    // wrap: 20 write/read pairs, reading whenever data is present
    for (int i = 0; i < 20; i++) begin
      wr_cnt++;
      cyc(!me, 1'b0, 1'b0);
    end
    for (int i = 0; i < 10 && !me; i++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("bin_wrap",  32'(saw_bin_wrap),  32'd1);
    chk("gray_wrap", 32'(saw_gray_wrap), 32'd1);
    chk("addr_wrap", 32'(saw_addr_wrap), 32'd1);

    // almost-empty: fill 4, drain through 4,3,2,1,0
    for (int i = 0; i < 4; i++) begin
      wr_cnt++;
      cyc(1'b0, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b0, 1'b0);
    chk("ae_at4", 32'(rif.f_almost_empty), 32'd0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    // concurrent write and read at level 3, then reset mid-stream
    for (int i = 0; i < 3; i++) begin
      wr_cnt++;
      cyc(1'b0, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b0, 1'b0);
    wr_cnt++;
    cyc(1'b1, 1'b0, 1'b0);
    chk("concurrent_level", 32'(rif.rd_level), 32'd3);
    cyc(1'b1, 1'b0, 1'b0);
    chk("concurrent_vld", 32'(rif.rd_valid), 32'd1);
    cyc(1'b1, 1'b0, 1'b1);
    wr_cnt = 0;
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
